// File: rtl/dm_pkg.sv
// dm_pkg: state encoding and sizing helpers shared by data_memory_be and its storage bank
package dm_pkg;
    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;
    localparam int MAX_DW = 1024;
    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction
    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction
    function automatic logic [MAX_DW-1:0] zext8(input logic [7:0] b);
        return {{(MAX_DW-8){1'b0}}, b};
    endfunction
endpackage

// File: rtl/dm_bank.sv
// dm_bank: word storage with per-byte write enables and a write-first registered read port
module dm_bank
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int BYTES      = bytes_of(DATA_WIDTH),
    parameter int IW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [IW-1:0]         i_addr,
    input  logic [BYTES-1:0]      i_we,
    input  logic [DATA_WIDTH-1:0] i_wd,
    input  logic                  i_re,
    output logic [DATA_WIDTH-1:0] o_rd
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] w_merged;
    // read path sees the lanes being written this cycle
    always_comb begin
        w_merged = r_mem[i_addr];
        for (int b = 0; b < BYTES; b++)
            if (i_we[b]) w_merged[b*8 +: 8] = i_wd[b*8 +: 8];
    end
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BYTES; b++)
            if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wd[b*8 +: 8];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rd <= '0;
        else if (i_re) r_rd <= w_merged;
    end
    assign o_rd = r_rd;
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressable data memory with registered read, address error pulses
// and a clear-on-reset sequence that zeroes every word before accepting requests
module data_memory_be
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic [ADDR_WIDTH-1:0] Adresa,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  ByteMode,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  AddrError,
    output logic                  Busy
);
    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int LB    = lane_bits(DATA_WIDTH);
    localparam int IW    = $clog2(DEPTH);
    state_t                r_state, w_next;
    logic [IW-1:0]         r_cnt;
    logic                  r_rv, r_ae, r_rd_zero, r_rd_byte;
    logic [LB-1:0]         r_lane;
    logic [LB-1:0]         w_lane;
    logic                  w_idle, w_req, w_err, w_ok;
    logic [BYTES-1:0]      w_we;
    logic [IW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_wd, w_bank_rd;
    logic [7:0]            w_lane_byte;

    assign w_lane = Adresa[LB-1:0];
    assign w_idle = r_state == ST_IDLE;
    assign w_req  = MemRead | MemWrite;
    assign w_err  = (!ByteMode && w_lane != '0) || ((Adresa >> LB) >= ADDR_WIDTH'(DEPTH));
    assign w_ok   = w_idle && !w_err;
    // during clear the bank is driven by the counter with zero data on all lanes
    assign w_addr = w_idle ? Adresa[LB +: IW] : r_cnt;
    assign w_we   = !w_idle ? {BYTES{1'b1}} :
                    (MemWrite && w_ok) ? (ByteMode ? BYTES'(1) << w_lane : {BYTES{1'b1}}) : {BYTES{1'b0}};
    assign w_wd   = !w_idle ? '0 : ByteMode ? {BYTES{WD[7:0]}} : WD;

    dm_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_bank (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wd    (w_wd),
        .i_re    (MemRead && w_ok),
        .o_rd    (w_bank_rd)
    );

    assign w_lane_byte = w_bank_rd[r_lane*8 +: 8];
    assign ReadData    = r_rd_zero ? '0 : r_rd_byte ? DATA_WIDTH'(zext8(w_lane_byte)) : w_bank_rd;
    assign ReadValid   = r_rv;
    assign AddrError   = r_ae;
    assign Busy        = !w_idle;

    always_comb begin
        w_next = r_state;
        if (r_state == ST_CLEAR && r_cnt == IW'(DEPTH - 1)) w_next = ST_IDLE;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_CLEAR;
            r_cnt     <= '0;
            r_rv      <= 1'b0;
            r_ae      <= 1'b0;
            r_rd_zero <= 1'b1;
            r_rd_byte <= 1'b0;
            r_lane    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_idle ? r_cnt : r_cnt + 1'b1;
            r_rv    <= w_idle && MemRead;
            r_ae    <= w_idle && w_req && w_err;
            // error reads return zero; the format of the last accepted read is kept
            if (w_idle && MemRead) begin
                r_rd_zero <= w_err;
                r_rd_byte <= ByteMode;
                r_lane    <= w_lane;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: directed vector table plus reset/clear sequences for data_memory_be
module tb_data_memory_be;
    typedef struct {
        logic        we;
        logic        re;
        logic        bm;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        rv;
        logic        ae;
        logic [15:0] rd;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        MemWrite = 1'b0, MemRead = 1'b0, ByteMode = 1'b0;
    logic [15:0] WD = '0, Adresa = '0;
    logic [15:0] ReadData;
    logic        ReadValid, AddrError, Busy;
    int          total = 0, bad = 0;
    vec_t        tbl[$];

    always #5 Clock = ~Clock;

    data_memory_be #(.DATA_WIDTH(16), .DEPTH(256), .ADDR_WIDTH(16)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .WD        (WD),
        .Adresa    (Adresa),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ByteMode  (ByteMode),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .AddrError (AddrError),
        .Busy      (Busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        ByteMode = 1'b0;
        Adresa   = '0;
        WD       = '0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge Clock);
        MemWrite = v.we;
        MemRead  = v.re;
        ByteMode = v.bm;
        Adresa   = v.addr;
        WD       = v.wd;
        @(posedge Clock);
        #1;
        chk({tag, " ReadValid"}, ReadValid, v.rv);
        chk({tag, " AddrError"}, AddrError, v.ae);
        chk({tag, " ReadData"}, ReadData, v.rd);
    endtask

    // releases reset, counts Busy cycles and pokes requests mid-clear
    task automatic run_clear(input string tag);
        int   n = 0;
        logic seen = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        while (Busy && n < 1000) begin
            @(posedge Clock);
            #1;
            n++;
            seen |= ReadValid | AddrError;
            if (n == 10) begin
                MemWrite = 1'b1;
                MemRead  = 1'b1;
                Adresa   = 16'd4;
                WD       = 16'hBEEF;
            end
            if (n == 12) idle_inputs();
        end
        idle_inputs();
        chk({tag, " busy cycles"}, n, 256);
        chk({tag, " quiet while busy"}, seen, 1'b0);
    endtask

    initial begin
        //                 we re bm addr     wd        rv ae rd
        tbl.push_back('{0, 1, 0, 16'd20,  16'h0000, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 0, 16'd0,   16'h0000, 0, 0, 16'h0000});
        tbl.push_back('{1, 0, 0, 16'd20,  16'h1234, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 0, 16'd20,  16'h0000, 1, 0, 16'h1234});
        tbl.push_back('{0, 0, 0, 16'd0,   16'h0000, 0, 0, 16'h1234});
        tbl.push_back('{1, 0, 1, 16'd21,  16'h00AB, 0, 0, 16'h1234});
        tbl.push_back('{0, 1, 0, 16'd20,  16'h0000, 1, 0, 16'hAB34});
        tbl.push_back('{0, 1, 1, 16'd20,  16'h0000, 1, 0, 16'h0034});
        tbl.push_back('{0, 1, 1, 16'd21,  16'h0000, 1, 0, 16'h00AB});
        tbl.push_back('{1, 0, 0, 16'd21,  16'hFFFF, 0, 1, 16'h00AB});
        tbl.push_back('{0, 0, 0, 16'd0,   16'h0000, 0, 0, 16'h00AB});
        tbl.push_back('{0, 1, 0, 16'd20,  16'h0000, 1, 0, 16'hAB34});
        tbl.push_back('{0, 1, 0, 16'd512, 16'h0000, 1, 1, 16'h0000});
        tbl.push_back('{1, 1, 0, 16'd20,  16'h5555, 1, 0, 16'h5555});
        tbl.push_back('{1, 1, 1, 16'd21,  16'h0077, 1, 0, 16'h0077});
        tbl.push_back('{0, 1, 0, 16'd20,  16'h0000, 1, 0, 16'h7755});
        tbl.push_back('{0, 1, 0, 16'd4,   16'h0000, 1, 0, 16'h0000});
        tbl.push_back('{0, 1, 0, 16'd21,  16'h0000, 1, 1, 16'h0000});
        tbl.push_back('{1, 0, 0, 16'd510, 16'h9ABC, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 1, 16'd511, 16'h0000, 1, 0, 16'h009A});
        tbl.push_back('{0, 1, 0, 16'd510, 16'h0000, 1, 0, 16'h9ABC});
        tbl.push_back('{0, 1, 1, 16'd512, 16'h0000, 1, 1, 16'h0000});

        #12;
        chk("reset Busy", Busy, 1'b1);
        chk("reset ReadValid", ReadValid, 1'b0);
        chk("reset AddrError", AddrError, 1'b0);
        chk("reset ReadData", ReadData, 16'h0000);
        run_clear("first clear");

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // error read in flight, then reset lands before its pulse is consumed
        @(negedge Clock);
        MemRead = 1'b1;
        Adresa  = 16'd512;
        @(posedge Clock);
        #1;
        chk("pre-reset AddrError", AddrError, 1'b1);
        Reset = 1'b0;
        idle_inputs();
        #1;
        chk("mid reset Busy", Busy, 1'b1);
        chk("mid reset ReadValid", ReadValid, 1'b0);
        chk("mid reset AddrError", AddrError, 1'b0);
        chk("mid reset ReadData", ReadData, 16'h0000);
        #20;
        run_clear("second clear");
        apply("after reset word20", '{0, 1, 0, 16'd20, 16'h0000, 1, 0, 16'h0000});
        apply("after reset word510", '{0, 1, 0, 16'd510, 16'h0000, 1, 0, 16'h0000});
        apply("after reset idle", '{0, 0, 0, 16'd0, 16'h0000, 0, 0, 16'h0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
